// File: rtl/ib_credit_fifo_pkg.sv
// Shared NoC definitions: destination port codes, default flit width and
// the position of the destination field inside a flit.
package noc_pkg;

  typedef logic [2:0] port_addr_t;

  localparam port_addr_t PORT_NORTH = 3'b000;
  localparam port_addr_t PORT_SOUTH = 3'b001;
  localparam port_addr_t PORT_EAST  = 3'b010;
  localparam port_addr_t PORT_WEST  = 3'b011;
  localparam port_addr_t PORT_LOCAL = 3'b100;

  localparam int DEFAULT_FLIT_W = 32;

  // Destination field occupies the top three bits of a default-width flit.
  localparam int DEST_MSB = DEFAULT_FLIT_W - 1;
  localparam int DEST_LSB = DEFAULT_FLIT_W - 3;

endpackage

// File: rtl/ib_credit_fifo_if.sv
// Link-side and route-side signals of one router input buffer.
// Optional stats outputs exist only when IB_STATS_EN is defined.
interface ib_credit_fifo_if #(
  parameter int FLIT_W = noc_pkg::DEFAULT_FLIT_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) ();
  import noc_pkg::*;

  // Handshake: flit_valid_i has no ready; the upstream FCU only sends while it
  // holds a credit, so every valid flit is taken in the cycle it is presented.
  // deq_i consumes the head flit in the same cycle when req_valid_o is high;
  // credit_en_o returns one credit per consumed flit, one cycle later.
  logic [FLIT_W-1:0] flit_i;
  logic              flit_valid_i;
  logic              deq_i;
  logic [FLIT_W-1:0] flit_o;
  logic              req_valid_o;
  port_addr_t        req_port_addr_o;
  logic              full_o;
  logic [CNT_W-1:0]  count_o;
  logic              credit_en_o;
  logic              overflow_err_o;
  logic              underflow_err_o;
`ifdef IB_STATS_EN
  logic [15:0]       rx_count_o;
  logic [15:0]       drop_count_o;
`endif

  modport slave (
    input  flit_i, flit_valid_i, deq_i,
    output flit_o, req_valid_o, req_port_addr_o, full_o, count_o,
           credit_en_o, overflow_err_o, underflow_err_o
`ifdef IB_STATS_EN
    , output rx_count_o, drop_count_o
`endif
  );

  modport master (
    output flit_i, flit_valid_i, deq_i,
    input  flit_o, req_valid_o, req_port_addr_o, full_o, count_o,
           credit_en_o, overflow_err_o, underflow_err_o
`ifdef IB_STATS_EN
    , input rx_count_o, drop_count_o
`endif
  );

endinterface

// File: rtl/ib_credit_fifo_core.sv
// Circular buffer with separate occupancy count. push_i/pop_i must already be
// qualified by the caller (no push when full without pop, no pop when empty).
module ib_fifo_core #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ib_credit_fifo.sv
// Router input-port buffer: downstream end of the credit link. Returns one
// credit per dequeued flit. Optional stats counters under IB_STATS_EN.
module ib_credit_fifo
  import noc_pkg::*;
#(
  parameter int FLIT_W = DEFAULT_FLIT_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  ib_credit_fifo_if.slave  bus
);
  // Destination field keeps its distance from the flit MSB at any width.
  localparam int DMSB = FLIT_W - 1 - (DEFAULT_FLIT_W - 1 - DEST_MSB);
  localparam int DLSB = FLIT_W - 1 - (DEFAULT_FLIT_W - 1 - DEST_LSB);

  logic              full, empty;
  logic              push_ok, pop_ok;
  logic [FLIT_W-1:0] head;
  logic [CNT_W-1:0]  count;
  logic              credit_q, credit_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  // A dequeue on a full buffer frees the slot the concurrent write needs.
  assign pop_ok  = bus.deq_i && !empty;
  assign push_ok = bus.flit_valid_i && (!full || pop_ok);

  ib_fifo_core #(.W(FLIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_ok),
    .pop_i   (pop_ok),
    .wdata_i (bus.flit_i),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    credit_d = pop_ok;
    ovf_d    = ovf_q || (bus.flit_valid_i && full && !bus.deq_i);
    udf_d    = udf_q || (bus.deq_i && empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign bus.flit_o          = empty ? '0 : head;
  assign bus.req_valid_o     = !empty;
  assign bus.req_port_addr_o = empty ? PORT_NORTH : port_addr_t'(head[DMSB:DLSB]);
  assign bus.full_o          = full;
  assign bus.count_o         = count;
  assign bus.credit_en_o     = credit_q;
  assign bus.overflow_err_o  = ovf_q;
  assign bus.underflow_err_o = udf_q;

`ifdef IB_STATS_EN
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop;

  assign drop = bus.flit_valid_i && !push_ok;

  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (push_ok && rx_cnt_q != 16'hFFFF)   rx_cnt_d   = rx_cnt_q + 16'd1;
    if (drop && drop_cnt_q != 16'hFFFF)    drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.rx_count_o   = rx_cnt_q;
  assign bus.drop_count_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ib_credit_fifo.sv
// Directed bench for ib_credit_fifo (DEPTH=4, FLIT_W=32); stats checks are
// compiled in when IB_STATS_EN is defined.
module tb_ib_credit_fifo;
  import noc_pkg::*;

  localparam int FLIT_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [FLIT_W-1:0] exp_q[$];
  logic [FLIT_W-1:0] exp_flit;

  ib_credit_fifo_if #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  ib_credit_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.flit_i       = '0;
    bus.flit_valid_i = 1'b0;
    bus.deq_i        = 1'b0;
    rst_n            = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic write_flit(input logic [FLIT_W-1:0] f, input bool_exp_accept);
    bus.flit_i       = f;
    bus.flit_valid_i = 1'b1;
    step();
    bus.flit_valid_i = 1'b0;
    if (bool_exp_accept) exp_q.push_back(f);
  endtask

  // Check head against the scoreboard, dequeue it, check the credit pulse.
  task automatic deq_check(input string tag);
    exp_flit = exp_q.pop_front();
    check({tag, "_head"}, bus.flit_o, exp_flit);
    check({tag, "_addr"}, {29'd0, bus.req_port_addr_o}, {29'd0, exp_flit[31:29]});
    bus.deq_i = 1'b1;
    step();
    bus.deq_i = 1'b0;
    check({tag, "_credit"}, {31'd0, bus.credit_en_o}, 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset then idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      check("idle_count",  {29'd0, bus.count_o}, 32'd0);
      check("idle_valid",  {31'd0, bus.req_valid_o}, 32'd0);
      check("idle_addr",   {29'd0, bus.req_port_addr_o}, 32'd0);
      check("idle_credit", {31'd0, bus.credit_en_o}, 32'd0);
      check("idle_full",   {31'd0, bus.full_o}, 32'd0);
      check("idle_errs",   {30'd0, bus.overflow_err_o, bus.underflow_err_o}, 32'd0);
      step();
    end

    // Single flit, then dequeue: credit exactly one cycle after the deq edge
    write_flit(32'h4000_00AA, 1'b1);
    check("one_valid", {31'd0, bus.req_valid_o}, 32'd1);
    check("one_addr",  {29'd0, bus.req_port_addr_o}, {29'd0, PORT_EAST});
    check("one_count", {29'd0, bus.count_o}, 32'd1);
    check("one_nocred", {31'd0, bus.credit_en_o}, 32'd0);
    deq_check("one_deq");
    check("one_empty", {31'd0, bus.req_valid_o}, 32'd0);
    step();
    check("one_cred_done", {31'd0, bus.credit_en_o}, 32'd0);

    // Fill, overflow, drain in order
    write_flit(32'h0000_0001, 1'b1);
    write_flit(32'h2000_0002, 1'b1);
    write_flit(32'h6000_0003, 1'b1);
    write_flit(32'h8000_0004, 1'b1);
    check("fill_full",  {31'd0, bus.full_o}, 32'd1);
    check("fill_count", {29'd0, bus.count_o}, 32'd4);
    check("fill_ovf0",  {31'd0, bus.overflow_err_o}, 32'd0);
    write_flit(32'hE000_0005, 1'b0);
    check("ovf_flag",  {31'd0, bus.overflow_err_o}, 32'd1);
    check("ovf_count", {29'd0, bus.count_o}, 32'd4);
    check("ovf_nocred", {31'd0, bus.credit_en_o}, 32'd0);
`ifdef IB_STATS_EN
    check("stats_rx",   {16'd0, bus.rx_count_o}, 32'd5);
    check("stats_drop", {16'd0, bus.drop_count_o}, 32'd1);
`endif
    for (int i = 0; i < 4; i++) deq_check("drain");
    check("drain_count", {29'd0, bus.count_o}, 32'd0);
    step();
    check("drain_cred_end", {31'd0, bus.credit_en_o}, 32'd0);
    check("ovf_sticky", {31'd0, bus.overflow_err_o}, 32'd1);

    // Full buffer, simultaneous write and dequeue
    do_reset();
    write_flit(32'h0000_00A0, 1'b1);
    write_flit(32'h2000_00B0, 1'b1);
    write_flit(32'h4000_00C0, 1'b1);
    write_flit(32'h6000_00D0, 1'b1);
    exp_flit = exp_q.pop_front();
    check("fwd_head", bus.flit_o, exp_flit);
    bus.flit_i       = 32'h8000_00E0;
    bus.flit_valid_i = 1'b1;
    bus.deq_i        = 1'b1;
    step();
    bus.flit_valid_i = 1'b0;
    bus.deq_i        = 1'b0;
    exp_q.push_back(32'h8000_00E0);
    check("fwd_count",  {29'd0, bus.count_o}, 32'd4);
    check("fwd_ovf",    {31'd0, bus.overflow_err_o}, 32'd0);
    check("fwd_credit", {31'd0, bus.credit_en_o}, 32'd1);
    step();
    check("fwd_cred_once", {31'd0, bus.credit_en_o}, 32'd0);
    for (int i = 0; i < 4; i++) deq_check("fwd_drain");
    check("fwd_last_local", {29'd0, exp_flit[31:29]}, {29'd0, PORT_LOCAL});

    // Dequeue on empty
    step();
    check("udf_pre", {31'd0, bus.underflow_err_o}, 32'd0);
    bus.deq_i = 1'b1;
    step();
    bus.deq_i = 1'b0;
    check("udf_flag",   {31'd0, bus.underflow_err_o}, 32'd1);
    check("udf_nocred", {31'd0, bus.credit_en_o}, 32'd0);
    step();
    check("udf_sticky", {31'd0, bus.underflow_err_o}, 32'd1);

    // Write and dequeue together on empty: write lands, dequeue ignored
    do_reset();
    bus.flit_i       = 32'h6000_0077;
    bus.flit_valid_i = 1'b1;
    bus.deq_i        = 1'b1;
    step();
    bus.flit_valid_i = 1'b0;
    bus.deq_i        = 1'b0;
    check("wde_count",  {29'd0, bus.count_o}, 32'd1);
    check("wde_udf",    {31'd0, bus.underflow_err_o}, 32'd1);
    check("wde_nocred", {31'd0, bus.credit_en_o}, 32'd0);
    check("wde_addr",   {29'd0, bus.req_port_addr_o}, {29'd0, PORT_WEST});

    // Asynchronous reset mid-drain with count=2
    do_reset();
    write_flit(32'h2000_0011, 1'b1);
    write_flit(32'h2000_0022, 1'b1);
    write_flit(32'h2000_0033, 1'b1);
    bus.deq_i = 1'b1;
    step();
    bus.deq_i = 1'b0;
    check("mid_count",  {29'd0, bus.count_o}, 32'd2);
    check("mid_credit", {31'd0, bus.credit_en_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count",  {29'd0, bus.count_o}, 32'd0);
    check("arst_credit", {31'd0, bus.credit_en_o}, 32'd0);
    check("arst_valid",  {31'd0, bus.req_valid_o}, 32'd0);
    step();
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_credit", {31'd0, bus.credit_en_o}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
